mem_arbiter: RTL
================

# mem_arbiter

Two-port round-robin arbiter sharing the single Avalon-MM memory master of the MIPS CPU between the instruction-fetch port (read-only) and the data port (read/write). Sits between the CPU/cache requesters and the external Avalon slave. Serialises transfers, passes the slave handshake through to the granted requester, and aborts transfers the slave stalls for too long.

## Interface
- TIMEOUT, 16: stall cycles (m_waitrequest=1 while granted) before a transfer is aborted; legal range 2..255.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_address  in  32  instruction read address (word aligned).
- i_read  in  1  instruction read request; held until i_waitrequest=0.
- i_waitrequest  out  1  stall to instruction port.
- i_readdata  out  32  instruction read data.
- d_address  in  32  data address.
- d_read, d_write  in  1 each  data request; mutually exclusive; held until d_waitrequest=0.
- d_writedata  in  32  write data.
- d_byteenable  in  4  byte lanes.
- d_waitrequest  out  1  stall to data port.
- d_readdata  out  32  data read data.
- m_address  out  32; m_read, m_write  out  1; m_writedata  out  32; m_byteenable  out  4  Avalon master request.
- m_waitrequest  in  1; m_readdata  in  32  Avalon master response.
- error  out  1  sticky; set on any timeout abort.

## Operation
- States: IDLE, GNT_I, GNT_D, ABORT. Registers: state, last_grant (I/D), stall counter, error.
- IDLE: master outputs all 0; i_waitrequest=d_waitrequest=1. On edge with request(s) pending:
  - only i_read -> GNT_I; only d_read|d_write -> GNT_D.
  - both -> grant port opposite to last_grant.
- GNT_x: m_address/m_read/m_write/m_writedata/m_byteenable driven combinationally from port x (instruction port: m_write=0, m_byteenable=4'hF, m_writedata=0). x_waitrequest = m_waitrequest; other port waitrequest=1.
- Completion: edge where state=GNT_x and m_waitrequest=0 -> last_grant<=x, counter<=0, next IDLE.
- Stall: each edge in GNT_x with m_waitrequest=1 increments counter; when counter reaches TIMEOUT-1 on such an edge -> ABORT.
- ABORT (1 cycle): master outputs 0; granted port x_waitrequest=0, x_readdata=0; other port waitrequest=1; error<=1; next IDLE, last_grant<=x, counter<=0.
- i_readdata/d_readdata: m_readdata in GNT states, 0 in ABORT for granted port; don't-care otherwise.
- Requester dropping its request while granted: illegal (Avalon hold rule); behaviour unspecified; bench flags as protocol violation.
- error cleared only by reset.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, last_grant=D (instruction wins first tie), counter=0, error=0, m_read=m_write=0, m_address=m_writedata=0, m_byteenable=0, i_waitrequest=d_waitrequest=1. Reset mid-transfer drops master request immediately, no completion signalled.
- Grant latency: request sampled in IDLE at edge N; master request visible after edge N; requester sees waitrequest=0 earliest same cycle (zero-wait slave) -> completes at edge N+1.
- Minimum 2 cycles per transfer (IDLE + GNT); back-to-back requests from the same or other port always pass through one IDLE cycle.
- Abort occurs at edge TIMEOUT after entering GNT_x if slave never releases; ABORT completion seen at following edge.
- Fairness: with both ports continuously requesting, grants strictly alternate I, D, I, D.

## Test plan
- Single fetch: i_read, i_address=0x4, slave zero-wait returns 0x1234 -> m_read=1, m_address=0x4 one cycle after request; i_readdata=0x1234 with i_waitrequest=0; d_waitrequest stays 1.
- Simultaneous first requests after reset: i_read@0x8, d_read@0xFFFF0004 -> I granted first (0x4321), then IDLE, then D (0x11001001); next tie grants I.
- Continuous contention for 8 transfers -> grant order I,D,I,D,I,D,I,D; no port starved.
- Data write 0xDEADBEEF, byteenable 4'b0011, @0x10, slave waitrequest high 3 cycles -> m_write held with stable address/data/byteenable 3 cycles, d_waitrequest mirrors m_waitrequest, completes 4th cycle; error=0.
- Timeout: TIMEOUT=16, slave holds waitrequest=1 forever on d_read -> after 16 stall edges ABORT: d_waitrequest=0, d_readdata=0, m_read=0, error=1 and stays 1 across later good transfers.
- Reset mid-transfer: assert reset during GNT_D stall -> m_read/m_write drop to 0 asynchronously, error=0, both waitrequests 1; after release, tie grants I first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter: shares one Avalon-MM master between the
// instruction-fetch port (read-only) and the data port (read/write).
// Transfers are serialised through an IDLE cycle, the slave handshake is
// passed straight through to the granted port, and stalls longer than
// TIMEOUT cycles are aborted with a sticky error flag.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,

    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,

    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,

    output logic        error
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ABORT} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    port_t      last_q;
    logic [7:0] cnt_q;
    logic       error_q;

    logic       req_i;
    logic       req_d;
    port_t      cur_port;

    assign req_i    = i_read;
    assign req_d    = d_read | d_write;
    assign cur_port = (state_q == GNT_I) ? PORT_I : PORT_D;
    assign error    = error_q;

    // Arbitration, completion and stall-timeout sequencing.
    // last_q is updated on entry to ABORT so the ABORT cycle knows which port
    // to release; IDLE arbitration only ever sees the post-transfer value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= PORT_D;
            cnt_q   <= 8'd0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && (!req_d || last_q == PORT_D)) begin
                        state_q <= GNT_I;
                    end else if (req_d) begin
                        state_q <= GNT_D;
                    end
                end
                GNT_I, GNT_D: begin
                    if (!m_waitrequest) begin
                        state_q <= IDLE;
                        last_q  <= cur_port;
                        cnt_q   <= 8'd0;
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= ABORT;
                        last_q  <= cur_port;
                        cnt_q   <= 8'd0;
                        error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ABORT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Master request mux and handshake steering to the granted port.
    always_comb begin
        m_address     = 32'd0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = 32'd0;
        m_byteenable  = 4'h0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        i_readdata    = 32'd0;
        d_readdata    = 32'd0;
        case (state_q)
            GNT_I: begin
                m_address     = i_address;
                m_read        = i_read;
                m_byteenable  = 4'hF;
                i_waitrequest = m_waitrequest;
                i_readdata    = m_readdata;
            end
            GNT_D: begin
                m_address     = d_address;
                m_read        = d_read;
                m_write       = d_write;
                m_writedata   = d_writedata;
                m_byteenable  = d_byteenable;
                d_waitrequest = m_waitrequest;
                d_readdata    = m_readdata;
            end
            ABORT: begin
                if (last_q == PORT_I) begin
                    i_waitrequest = 1'b0;
                end else begin
                    d_waitrequest = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
